parking_gate_ctrl: RTL and testbench
====================================

// Module: parking_gate_ctrl
// PURPOSE
//  Consumes 1-cycle entry/exit pulses from the button debouncers and arbitrates them onto one shared gate.
//  Sequences the gate through open, car-pass wait and close phases, and tracks lot occupancy.
//  Rejects entries when the lot is full and exits when it is empty.
//  Sits between the Debouncer instances and the gate actuator / seven-segment occupancy display.
// PARAMETERS
//  CLK_FREQUENCY     40_000_000  clock rate in Hz; documentation only, no logic derives from it
//  CAPACITY          8           number of parking spaces; must be >= 1
//  CNT_W             4           occupancy width; 2**CNT_W must be > CAPACITY
//  GATE_OPEN_CYCLES  400_000_000 max cycles the gate stays open waiting for car_passed
//  CLOSE_CYCLES      40_000_000  cycles spent in CLOSE before the next grant
//  TMR_W             32          timer width; must hold max(GATE_OPEN_CYCLES, CLOSE_CYCLES)
// PORTS
//  clk          in   1      clock
//  reset_n      in   1      asynchronous reset, active-low
//  entry_req    in   1      1-cycle pulse: car wants in (debounced)
//  exit_req     in   1      1-cycle pulse: car wants out (debounced)
//  car_passed   in   1      async level from the gate sensor; 2-FF synchronised internally
//  gate_open    out  1      1 = drive gate open
//  gate_dir     out  1      direction of current/last grant: 0 = entry, 1 = exit
//  occupied     out  CNT_W  cars currently in the lot
//  full         out  1      occupied == CAPACITY
//  empty        out  1      occupied == 0
//  busy         out  1      FSM not in IDLE
//  reject       out  1      1-cycle pulse: pending request dropped (entry while full, exit while empty)
//  alarm        out  1      present only with PARK_ALARM_EN
// BEHAVIOUR
//  Reset values: all outputs 0 except empty = 1; FSM = IDLE; pendings, timer, sync FFs and last_dir cleared.
//  Pending latches: entry_pend and exit_pend are each set by their req pulse in any state.
//  A req pulse while the matching pend is already set is dropped; pendings are never counters.
//  A pend clears when it is granted or rejected.
//  FSM states and transitions:
//   IDLE   neither pend set -> stay.
//          Only one pend set -> serve it.
//          Both set -> serve the direction opposite to last_dir (round-robin).
//          Serve entry: if full, clear entry_pend, pulse reject, stay IDLE; else go OPEN with gate_dir = 0.
//          Serve exit: if empty, clear exit_pend, pulse reject, stay IDLE; else go OPEN with gate_dir = 1.
//          On a grant, last_dir <= gate_dir, the pend is cleared and the timer is zeroed.
//          At most one grant or reject per cycle.
//   OPEN   gate_open = 1 and the timer increments.
//          Rising edge of synchronised car_passed -> occupied +1 (entry) or -1 (exit), then CLOSE.
//          Timer reaching GATE_OPEN_CYCLES-1 with no edge -> CLOSE; occupied unchanged.
//          If the edge and the timeout land on the same cycle, the edge wins (count updates).
//   CLOSE  gate_open = 0; the timer counts CLOSE_CYCLES cycles, then IDLE.
//          car_passed is ignored in CLOSE and IDLE.
//  Latency:
//   A req pulse at cycle N sets its pend at N+1.
//   If IDLE and eligible at N+1, gate_open = 1 from N+2.
//   A reject pulse is at N+2.
//  Occupancy:
//   Grant rules keep 0 <= occupied <= CAPACITY; occupied never wraps.
//   full and empty are registered and update in the same cycle as occupied.
//  Simultaneous entry_req and exit_req in one cycle: both pends set; round-robin decides the order.
//  Reset mid-operation: gate_open drops immediately (async); occupancy is lost and returns to 0.
// CONFIGURATION
//  PARK_ALARM_EN defined:
//   alarm asserts for CLOSE_CYCLES cycles after an entry reject, or after an OPEN timeout.
//   A new trigger reloads the alarm counter.
//   Reset value of alarm is 0.
//  PARK_ALARM_EN undefined: the alarm port and its counter do not exist.
// TESTING
//  The bench uses CAPACITY=2, GATE_OPEN_CYCLES=16, CLOSE_CYCLES=4.
//  1. entry_req pulse at cycle 10, car_passed high at cycle 15
//     -> gate_open 1 from cycle 12, gate_dir 0, occupied 1, CLOSE then IDLE.
//  2. Two full entries, then a third entry_req
//     -> full=1, no gate_open, reject pulse 2 cycles after the req, occupied stays 2.
//  3. exit_req with occupied 0 -> reject pulse, empty stays 1, gate never opens.
//  4. occupied 1 with entry_req and exit_req in the same cycle, last_dir = 0
//     -> exit served first (occupied 0), then entry (occupied 1); exactly two OPEN phases.
//  5. Entry granted with car_passed never asserted
//     -> gate_open high for exactly 16 cycles, occupied unchanged, alarm high 4 cycles when PARK_ALARM_EN.
//  6. reset_n low while in OPEN -> gate_open 0 asynchronously, occupied 0, empty 1, busy 0.

Source files
------------

// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: arbitrates entry/exit requests onto one gate.
// Optional alarm output enabled by defining PARK_ALARM_EN.
module parking_gate_ctrl #(
  parameter int CLK_FREQUENCY    = 40_000_000,
  parameter int CAPACITY         = 8,
  parameter int CNT_W            = 4,
  parameter int GATE_OPEN_CYCLES = 400_000_000,
  parameter int CLOSE_CYCLES     = 40_000_000,
  parameter int TMR_W            = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             car_passed,
  output logic             gate_open,
  output logic             gate_dir,
  output logic [CNT_W-1:0] occupied,
  output logic             full,
  output logic             empty,
  output logic             busy,
`ifdef PARK_ALARM_EN
  output logic             alarm,
`endif
  output logic             reject
);

  if (CLK_FREQUENCY <= 0 || CAPACITY < 1 ||
      (1 << CNT_W) <= CAPACITY) begin : g_param_chk
    $error("parking_gate_ctrl: bad parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OPEN  = 2'd1,
    S_CLOSE = 2'd2
  } state_e;

  localparam logic [TMR_W-1:0] OPEN_LAST  = TMR_W'(GATE_OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] CLOSE_LAST = TMR_W'(CLOSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP        = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             ep_q, ep_d;
  logic             xp_q, xp_d;
  logic             last_q, last_d;
  logic             dir_q, dir_d;
  logic             rej_q, rej_d;
  logic             full_q, empty_q;
  logic             cp_s1_q, cp_s2_q, cp_s3_q;
  logic             cp_rise;
  logic             take_exit;

  assign cp_rise   = cp_s2_q & ~cp_s3_q;
  assign take_exit = xp_q & (~ep_q | ~last_q);

  // Car sensor synchroniser plus one stage for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cp_s1_q <= 1'b0;
      cp_s2_q <= 1'b0;
      cp_s3_q <= 1'b0;
    end else begin
      cp_s1_q <= car_passed;
      cp_s2_q <= cp_s1_q;
      cp_s3_q <= cp_s2_q;
    end
  end

  // Next-state: arbitration, gate sequencing, occupancy and pend latches.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    occ_d   = occ_q;
    ep_d    = ep_q;
    xp_d    = xp_q;
    last_d  = last_q;
    dir_d   = dir_q;
    rej_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (take_exit) begin
          xp_d = 1'b0;
          if (empty_q) begin
            rej_d = 1'b1;
          end else begin
            state_d = S_OPEN;
            timer_d = '0;
            dir_d   = 1'b1;
            last_d  = 1'b1;
          end
        end else if (ep_q) begin
          ep_d = 1'b0;
          if (full_q) begin
            rej_d = 1'b1;
          end else begin
            state_d = S_OPEN;
            timer_d = '0;
            dir_d   = 1'b0;
            last_d  = 1'b0;
          end
        end
      end
      S_OPEN: begin
        if (cp_rise) begin
          occ_d   = dir_q ? occ_q - ONE : occ_q + ONE;
          state_d = S_CLOSE;
          timer_d = '0;
        end else if (timer_q == OPEN_LAST) begin
          state_d = S_CLOSE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_CLOSE: begin
        if (timer_q == CLOSE_LAST) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (entry_req) ep_d = 1'b1;
    if (exit_req)  xp_d = 1'b1;
  end

  // Controller state registers; full/empty track the next occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      occ_q   <= '0;
      ep_q    <= 1'b0;
      xp_q    <= 1'b0;
      last_q  <= 1'b0;
      dir_q   <= 1'b0;
      rej_q   <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      occ_q   <= occ_d;
      ep_q    <= ep_d;
      xp_q    <= xp_d;
      last_q  <= last_d;
      dir_q   <= dir_d;
      rej_q   <= rej_d;
      full_q  <= (occ_d == CAP);
      empty_q <= (occ_d == '0);
    end
  end

`ifdef PARK_ALARM_EN
  logic [TMR_W-1:0] alarm_cnt_q;
  logic             alarm_trig;

  assign alarm_trig =
    (state_q == S_IDLE && !take_exit && ep_q && full_q) ||
    (state_q == S_OPEN && !cp_rise && timer_q == OPEN_LAST);

  // Alarm holds for CLOSE_CYCLES after a full-lot reject or gate timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alarm_cnt_q <= '0;
    end else if (alarm_trig) begin
      alarm_cnt_q <= TMR_W'(CLOSE_CYCLES);
    end else if (alarm_cnt_q != '0) begin
      alarm_cnt_q <= alarm_cnt_q - 1'b1;
    end
  end

  assign alarm = (alarm_cnt_q != '0);
`endif

  assign gate_open = (state_q == S_OPEN);
  assign busy      = (state_q != S_IDLE);
  assign gate_dir  = dir_q;
  assign occupied  = occ_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign reject    = rej_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed scenarios plus random traffic
// checked every cycle against a behavioural lot/gate model.
module tb_parking_gate_ctrl;

  localparam int CAP = 2;
  localparam int GOC = 16;
  localparam int CC  = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          entry_req = 1'b0;
  logic          exit_req = 1'b0;
  logic          car_passed = 1'b0;
  logic          gate_open, gate_dir;
  logic          full, empty, busy, reject;
  logic [CW-1:0] occupied;
`ifdef PARK_ALARM_EN
  logic          alarm;
`endif

  int checks = 0;
  int failures = 0;
  int opens = 0;
  int n_open, n_alarm, opens0;
  bit prev_go = 1'b0;
  bit cp_lvl = 1'b0;
  bit re, rx;

  // model: phase 0 idle, 1 gate up, 2 closing
  int m_phase, m_cnt, m_occ, m_alarm;
  bit m_ep, m_xp, m_last, m_dir, m_rej;
  bit h1, h2, h3;

  always #5 clk = ~clk;

  parking_gate_ctrl #(
    .CAPACITY(CAP),
    .CNT_W(CW),
    .GATE_OPEN_CYCLES(GOC),
    .CLOSE_CYCLES(CC),
    .TMR_W(32)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .entry_req(entry_req),
    .exit_req(exit_req),
    .car_passed(car_passed),
    .gate_open(gate_open),
    .gate_dir(gate_dir),
    .occupied(occupied),
    .full(full),
    .empty(empty),
    .busy(busy),
`ifdef PARK_ALARM_EN
    .alarm(alarm),
`endif
    .reject(reject)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_occ = 0; m_alarm = 0;
    m_ep = 0; m_xp = 0; m_last = 0; m_dir = 0; m_rej = 0;
    h1 = 0; h2 = 0; h3 = 0;
  endtask

  task automatic model_step(input bit e, input bit x, input bit c);
    bit edge_s, ne, nx, trig, srv_x;
    edge_s = h2 && !h3;
    ne = m_ep; nx = m_xp; trig = 0; m_rej = 0;
    if (m_phase == 0) begin
      srv_x = m_xp && (!m_ep || !m_last);
      if (srv_x) begin
        nx = 0;
        if (m_occ == 0) m_rej = 1;
        else begin
          m_phase = 1; m_cnt = 0; m_dir = 1; m_last = 1;
        end
      end else if (m_ep) begin
        ne = 0;
        if (m_occ == CAP) begin
          m_rej = 1; trig = 1;
        end else begin
          m_phase = 1; m_cnt = 0; m_dir = 0; m_last = 0;
        end
      end
    end else if (m_phase == 1) begin
      if (edge_s) begin
        m_occ = m_dir ? m_occ - 1 : m_occ + 1;
        m_phase = 2; m_cnt = 0;
      end else if (m_cnt == GOC - 1) begin
        m_phase = 2; m_cnt = 0; trig = 1;
      end else m_cnt++;
    end else begin
      if (m_cnt == CC - 1) begin
        m_phase = 0; m_cnt = 0;
      end else m_cnt++;
    end
    m_ep = ne || e;
    m_xp = nx || x;
    if (trig) m_alarm = CC;
    else if (m_alarm > 0) m_alarm--;
    h3 = h2; h2 = h1; h1 = c;
  endtask

  task automatic check_all();
    chk("gate_open", gate_open, m_phase == 1);
    chk("gate_dir", gate_dir, m_dir);
    chk("occupied", occupied, m_occ);
    chk("full", full, m_occ == CAP);
    chk("empty", empty, m_occ == 0);
    chk("busy", busy, m_phase != 0);
    chk("reject", reject, m_rej);
`ifdef PARK_ALARM_EN
    chk("alarm", alarm, m_alarm > 0);
`endif
  endtask

  // drive one cycle of inputs, then sample at the next falling edge
  task automatic step(input bit e, input bit x, input bit c);
    entry_req = e; exit_req = x; car_passed = c;
    @(posedge clk);
    model_step(e, x, c);
    @(negedge clk);
    check_all();
    if (gate_open && !prev_go) opens++;
    prev_go = gate_open;
  endtask

  task automatic run(input int n, input bit c);
    for (int i = 0; i < n; i++) step(0, 0, c);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_all();
    chk("rst_gate", gate_open, 0);
    chk("rst_empty", empty, 1);
    chk("rst_occ", occupied, 0);
    chk("rst_busy", busy, 0);

    // exit while empty is rejected
    step(0, 1, 0);
    chk("s3_norej_n1", reject, 0);
    step(0, 0, 0);
    chk("s3_rej_n2", reject, 1);
    chk("s3_empty", empty, 1);
    run(6, 0);
    chk("s3_opens", opens, 0);

    // single entry with a passing car
    step(1, 0, 0);
    chk("s1_gate_n1", gate_open, 0);
    step(0, 0, 0);
    chk("s1_gate_n2", gate_open, 1);
    chk("s1_dir", gate_dir, 0);
    run(3, 0);
    run(12, 1);
    run(4, 0);
    chk("s1_occ", occupied, 1);
    chk("s1_idle", busy, 0);

    // simultaneous requests, last grant was entry
    opens0 = opens;
    step(1, 1, 0);
    step(0, 0, 0);
    chk("s4_dir_exit", gate_dir, 1);
    run(2, 0);
    run(10, 1);
    run(2, 0);
    run(10, 1);
    run(4, 0);
    chk("s4_occ", occupied, 1);
    chk("s4_opens", opens - opens0, 2);
    chk("s4_dir_last", gate_dir, 0);

    // fill the lot, then a rejected entry
    step(1, 0, 0);
    run(3, 0);
    run(10, 1);
    run(4, 0);
    chk("s2_full", full, 1);
    chk("s2_occ", occupied, 2);
    opens0 = opens;
    step(1, 0, 0);
    chk("s2_norej_n1", reject, 0);
    step(0, 0, 0);
    chk("s2_rej_n2", reject, 1);
    chk("s2_gate", gate_open, 0);
    run(6, 0);
    chk("s2_occ_keep", occupied, 2);
    chk("s2_no_open", opens - opens0, 0);

    // one exit, then an entry that times out
    step(0, 1, 0);
    run(3, 0);
    run(10, 1);
    run(4, 0);
    chk("s5_occ_pre", occupied, 1);
    step(1, 0, 0);
    n_open = 0; n_alarm = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0);
      if (gate_open) n_open++;
`ifdef PARK_ALARM_EN
      if (alarm) n_alarm++;
`endif
    end
    chk("s5_open_len", n_open, GOC);
    chk("s5_occ", occupied, 1);
`ifdef PARK_ALARM_EN
    chk("s5_alarm_len", n_alarm, CC);
`endif

    // random traffic
    for (int i = 0; i < 600; i++) begin
      re = ($urandom_range(0, 9) == 0);
      rx = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 4) == 0) cp_lvl = ~cp_lvl;
      step(re, rx, cp_lvl);
    end
    run(80, 0);

    // reset while the gate is up
    if (m_occ == CAP) step(0, 1, 0);
    else step(1, 0, 0);
    step(0, 0, 0);
    chk("s6_open", gate_open, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("s6_gate", gate_open, 0);
    chk("s6_occ", occupied, 0);
    chk("s6_empty", empty, 1);
    chk("s6_busy", busy, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    check_all();
    run(5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
